// File: rtl/sample_timing_controller.sv
// ---------------------------------------------------------------------------
// sample_timing_controller
//
// Generates the per-frame timing for an audio playback path. The SPI bus is
// shared by a sample flash and a multi-channel DAC. Each frame begins with a
// flash window: flash_cs is low, and sound_load pulses on the first cycle.
// Next comes the DAC window. In the DAC window, NUM_CH fixed-length slots
// each start with a DAC_load pulse. Any cycles left after the last slot form
// an idle tail, and then the frame wraps.
//
// A new period / flash window length arrives over a valid/ready handshake.
// The request is range-checked, held as pending, and applied only at a frame
// boundary (or straight away while idle). This means a frame never changes
// shape partway through.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-low
//   enable        run request; dropping it lets the current frame finish
//   cfg_valid     new timing offered
//   cfg_period    last count value of a frame (frame = period+1 cycles)
//   cfg_flash_lt  number of flash-window cycles at the start of a frame
//   cfg_ready     high while no configuration is pending
//   cfg_err       one-cycle pulse: offered configuration was rejected
//   spi_mux       SPI mux select, mirrors flash_cs
//   flash_cs      flash chip select, active-low
//   DAC_cs        DAC chip select, active-low
//   DAC_load      one-cycle pulse on the first cycle of each DAC slot
//   dac_ch        channel index of the current DAC slot (0 outside slots)
//   sound_load    one-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module sample_timing_controller #(
  parameter int CNT_W        = 11,
  parameter int NUM_CH       = 2,
  parameter int CH_W         = 1,
  parameter int SLOT_LEN     = 16,
  parameter int DEF_PERIOD   = 1134,
  parameter int DEF_FLASH_LT = 1100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_flash_lt,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             spi_mux,
  output logic             flash_cs,
  output logic             DAC_cs,
  output logic             DAC_load,
  output logic [CH_W-1:0]  dac_ch,
  output logic             sound_load
);

  // The extra 4 bits let slot boundaries run past the counter range without
  // wrapping back into a small value.
  localparam int EXT_W = CNT_W + 4;
  localparam logic [EXT_W-1:0] SLOT_SPAN = EXT_W'(NUM_CH * SLOT_LEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLASH = 2'd1;
  localparam logic [1:0] DAC   = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] flash_lt;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_flash_lt;

  logic             running;
  logic             at_wrap;
  logic             cfg_accept;
  logic             cfg_ok;
  logic [CNT_W-1:0] count_next;
  logic [EXT_W-1:0] slot_off;

  assign cfg_ready  = ~pend_valid;
  assign cfg_accept = cfg_valid & cfg_ready;

  // A configuration is usable only if the flash window is non-empty and all
  // of the DAC slots fit inside the frame.
  assign cfg_ok = (cfg_flash_lt != '0) &&
                  (({4'd0, cfg_flash_lt} + SLOT_SPAN) <= ({4'd0, cfg_period} + EXT_W'(1)));

  assign running    = (state == FLASH) || (state == DAC);
  assign at_wrap    = running && (count == period);
  assign count_next = count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      period        <= CNT_W'(DEF_PERIOD);
      flash_lt      <= CNT_W'(DEF_FLASH_LT);
      pend_valid    <= 1'b0;
      pend_period   <= '0;
      pend_flash_lt <= '0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= cfg_accept & ~cfg_ok;

      // An accept can only happen while nothing is pending, so it never
      // collides with an apply on the same edge. An accept that lands on a
      // wrap cycle sees pend_valid low, so it waits for the following wrap.
      if (cfg_accept && cfg_ok) begin
        pend_valid    <= 1'b1;
        pend_period   <= cfg_period;
        pend_flash_lt <= cfg_flash_lt;
      end else if (pend_valid && ((state == IDLE) || at_wrap)) begin
        period     <= pend_period;
        flash_lt   <= pend_flash_lt;
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          count <= '0;
          if (enable) begin
            state <= FLASH;
          end
        end
        FLASH, DAC: begin
          if (at_wrap) begin
            count <= '0;
            state <= enable ? FLASH : IDLE;
          end else begin
            count <= count_next;
            state <= (count_next < flash_lt) ? FLASH : DAC;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign flash_cs   = (state != FLASH);
  assign DAC_cs     = (state != DAC);
  assign spi_mux    = flash_cs;
  assign sound_load = (state == FLASH) && (count == '0);

  // When in DAC state, count >= flash_lt, so the offset never goes negative.
  assign slot_off = {4'd0, count} - {4'd0, flash_lt};

  // Walk the slots from highest to lowest. Each slot whose upper bound lies
  // above the offset overwrites the result, so the lowest such slot is the
  // one left at the end. Offsets past the last slot match nothing and leave
  // dac_ch at 0.
  always_comb begin
    DAC_load = 1'b0;
    dac_ch   = '0;
    if (state == DAC) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (slot_off < EXT_W'((k + 1) * SLOT_LEN)) begin
          dac_ch   = CH_W'(k);
          DAC_load = (slot_off == EXT_W'(k * SLOT_LEN));
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_timing_controller.sv
// ---------------------------------------------------------------------------
// tb_sample_timing_controller
//
// Directed testbench for sample_timing_controller with default parameters.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point. The measure_frame task follows one frame,
// starting from a known frame count, and records where the events fell. Each
// test task then compares those positions with hand-computed values.
// ---------------------------------------------------------------------------
module tb_sample_timing_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic [10:0] cfg_period;
  logic [10:0] cfg_flash_lt;
  logic        cfg_ready;
  logic        cfg_err;
  logic        spi_mux;
  logic        flash_cs;
  logic        DAC_cs;
  logic        DAC_load;
  logic [0:0]  dac_ch;
  logic        sound_load;

  int errors = 0;
  int checks = 0;

  int m_len, m_flash_last, m_dac_first, m_dac_last, m_nload;
  int m_load_a, m_load_b, m_ch_a, m_ch_b, m_nz;
  bit m_idle;

  always #5 clk = ~clk;

  sample_timing_controller #(
    .CNT_W(11), .NUM_CH(2), .CH_W(1), .SLOT_LEN(16),
    .DEF_PERIOD(1134), .DEF_FLASH_LT(1100)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_period(cfg_period), .cfg_flash_lt(cfg_flash_lt),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .spi_mux(spi_mux),
    .flash_cs(flash_cs), .DAC_cs(DAC_cs), .DAC_load(DAC_load),
    .dac_ch(dac_ch), .sound_load(sound_load)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a configuration for exactly one clock edge.
  task automatic send_cfg(input int per, input int flt);
    cfg_valid    = 1'b1;
    cfg_period   = 11'(per);
    cfg_flash_lt = 11'(flt);
    step();
    cfg_valid = 1'b0;
  endtask

  // Record event positions from frame count start_c until the next
  // sound_load or until both chip selects go idle. The loop is bounded, and
  // on timeout m_len stays -1.
  task automatic measure_frame(input int start_c);
    int c;
    c = start_c;
    m_len = -1; m_flash_last = -1; m_dac_first = -1; m_dac_last = -1;
    m_nload = 0; m_load_a = -1; m_load_b = -1; m_ch_a = -1; m_ch_b = -1;
    m_nz = 0; m_idle = 1'b0;
    for (int guard = 0; guard < 3000; guard++) begin
      if (!flash_cs) m_flash_last = c;
      if (!DAC_cs) begin
        if (m_dac_first < 0) m_dac_first = c;
        m_dac_last = c;
      end
      if (dac_ch != 1'b0) m_nz++;
      if (DAC_load) begin
        if (m_nload == 0) begin m_load_a = c; m_ch_a = int'(dac_ch); end
        else if (m_nload == 1) begin m_load_b = c; m_ch_b = int'(dac_ch); end
        m_nload++;
      end
      step();
      c++;
      if (sound_load) begin m_len = c; break; end
      if (flash_cs && DAC_cs) begin m_len = c; m_idle = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_flash_lt = '0;
    steps(3);
    checks++; if (flash_cs !== 1'b1) begin errors++; $display("[TB] FAIL reset_flash_cs: got %b expected 1", flash_cs); end
    checks++; if (DAC_cs !== 1'b1) begin errors++; $display("[TB] FAIL reset_DAC_cs: got %b expected 1", DAC_cs); end
    checks++; if (spi_mux !== 1'b1) begin errors++; $display("[TB] FAIL reset_spi_mux: got %b expected 1", spi_mux); end
    checks++; if (DAC_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_DAC_load: got %b expected 0", DAC_load); end
    checks++; if (sound_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_sound_load: got %b expected 0", sound_load); end
    checks++; if (dac_ch !== 1'b0) begin errors++; $display("[TB] FAIL reset_dac_ch: got %b expected 0", dac_ch); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    enable = 1'b1;
    steps(2);
    checks++; if (flash_cs !== 1'b1 || sound_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold_enable: got flash_cs=%b sound_load=%b expected 1/0", flash_cs, sound_load); end
  endtask

  task automatic test_default_frame();
    rst = 1'b1;
    step();
    checks++; if (sound_load !== 1'b1) begin errors++; $display("[TB] FAIL start_sound_load: got %b expected 1", sound_load); end
    checks++; if (flash_cs !== 1'b0 || spi_mux !== 1'b0 || DAC_cs !== 1'b1) begin errors++; $display("[TB] FAIL start_cs: got flash=%b mux=%b dac=%b expected 0/0/1", flash_cs, spi_mux, DAC_cs); end
    measure_frame(0);
    checks++; if (m_len !== 1135) begin errors++; $display("[TB] FAIL def_len: got %0d expected 1135", m_len); end
    checks++; if (m_flash_last !== 1099) begin errors++; $display("[TB] FAIL def_flash_last: got %0d expected 1099", m_flash_last); end
    checks++; if (m_dac_first !== 1100 || m_dac_last !== 1134) begin errors++; $display("[TB] FAIL def_dac_window: got %0d..%0d expected 1100..1134", m_dac_first, m_dac_last); end
    checks++; if (m_nload !== 2) begin errors++; $display("[TB] FAIL def_nload: got %0d expected 2", m_nload); end
    checks++; if (m_load_a !== 1100 || m_ch_a !== 0) begin errors++; $display("[TB] FAIL def_load0: got %0d ch %0d expected 1100 ch 0", m_load_a, m_ch_a); end
    checks++; if (m_load_b !== 1116 || m_ch_b !== 1) begin errors++; $display("[TB] FAIL def_load1: got %0d ch %0d expected 1116 ch 1", m_load_b, m_ch_b); end
    checks++; if (m_nz !== 16) begin errors++; $display("[TB] FAIL def_ch1_cycles: got %0d expected 16", m_nz); end
    checks++; if (m_idle !== 1'b0) begin errors++; $display("[TB] FAIL def_no_idle: got %b expected 0", m_idle); end
  endtask

  task automatic test_cfg_midframe();
    steps(300);
    send_cfg(199, 100);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_cfg_ready_low: got %b expected 0", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_cfg_err: got %b expected 0", cfg_err); end
    measure_frame(301);
    checks++; if (m_len !== 1135 || m_load_a !== 1100) begin errors++; $display("[TB] FAIL mid_cur_frame: got len %0d load %0d expected 1135 1100", m_len, m_load_a); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_cfg_ready_back: got %b expected 1", cfg_ready); end
    measure_frame(0);
    checks++; if (m_len !== 200) begin errors++; $display("[TB] FAIL new_len: got %0d expected 200", m_len); end
    checks++; if (m_flash_last !== 99 || m_dac_first !== 100 || m_dac_last !== 199) begin errors++; $display("[TB] FAIL new_windows: got %0d %0d %0d expected 99 100 199", m_flash_last, m_dac_first, m_dac_last); end
    checks++; if (m_load_a !== 100 || m_load_b !== 116 || m_ch_b !== 1) begin errors++; $display("[TB] FAIL new_loads: got %0d %0d ch %0d expected 100 116 ch 1", m_load_a, m_load_b, m_ch_b); end
    checks++; if (m_nz !== 16) begin errors++; $display("[TB] FAIL new_ch1_cycles: got %0d expected 16", m_nz); end
  endtask

  task automatic test_cfg_invalid();
    send_cfg(120, 100);
    checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL inv_err_pulse: got err=%b ready=%b expected 1/1", cfg_err, cfg_ready); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL inv_err_single: got %b expected 0", cfg_err); end
    send_cfg(199, 0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL inv_zero_flash: got %b expected 1", cfg_err); end
    step();
    send_cfg(130, 100);
    checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL inv_off_by_one: got err=%b ready=%b expected 1/1", cfg_err, cfg_ready); end
    step();
    measure_frame(6);
    checks++; if (m_len !== 200 || m_load_a !== 100) begin errors++; $display("[TB] FAIL inv_timing_kept: got len %0d load %0d expected 200 100", m_len, m_load_a); end
  endtask

  task automatic test_cfg_at_wrap();
    steps(199);
    send_cfg(131, 100);
    checks++; if (sound_load !== 1'b1 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_accept: got sl=%b ready=%b err=%b expected 1/0/0", sound_load, cfg_ready, cfg_err); end
    measure_frame(0);
    checks++; if (m_len !== 200) begin errors++; $display("[TB] FAIL wrap_old_kept: got %0d expected 200", m_len); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready_back: got %b expected 1", cfg_ready); end
    measure_frame(0);
    checks++; if (m_len !== 132 || m_dac_last !== 131) begin errors++; $display("[TB] FAIL wrap_new_len: got %0d last dac %0d expected 132 131", m_len, m_dac_last); end
    checks++; if (m_load_b !== 116 || m_nz !== 16) begin errors++; $display("[TB] FAIL wrap_full_slots: got load1 %0d ch1 cycles %0d expected 116 16", m_load_b, m_nz); end
  endtask

  task automatic test_enable_drop();
    send_cfg(1134, 1100);
    measure_frame(1);
    checks++; if (m_len !== 132) begin errors++; $display("[TB] FAIL drop_prep_len: got %0d expected 132", m_len); end
    steps(500);
    enable = 1'b0;
    measure_frame(500);
    checks++; if (m_idle !== 1'b1 || m_len !== 1135) begin errors++; $display("[TB] FAIL drop_frame_end: got idle=%b at %0d expected 1 at 1135", m_idle, m_len); end
    checks++; if (m_dac_last !== 1134 || m_load_b !== 1116) begin errors++; $display("[TB] FAIL drop_not_truncated: got dac_last %0d load1 %0d expected 1134 1116", m_dac_last, m_load_b); end
    steps(3);
    checks++; if (flash_cs !== 1'b1 || DAC_cs !== 1'b1 || sound_load !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle: got flash=%b dac=%b sl=%b expected 1/1/0", flash_cs, DAC_cs, sound_load); end
    send_cfg(199, 100);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_pending: got %b expected 0", cfg_ready); end
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_applied: got %b expected 1", cfg_ready); end
    enable = 1'b1;
    step();
    checks++; if (sound_load !== 1'b1) begin errors++; $display("[TB] FAIL reenable_sound_load: got %b expected 1", sound_load); end
    measure_frame(0);
    checks++; if (m_len !== 200) begin errors++; $display("[TB] FAIL idle_cfg_len: got %0d expected 200", m_len); end
  endtask

  task automatic test_reset_midframe();
    send_cfg(1134, 1100);
    measure_frame(1);
    checks++; if (m_len !== 200) begin errors++; $display("[TB] FAIL rmid_prep_len: got %0d expected 200", m_len); end
    steps(1105);
    send_cfg(199, 100);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pending: got %b expected 0", cfg_ready); end
    steps(4);
    checks++; if (DAC_cs !== 1'b0 || dac_ch !== 1'b0) begin errors++; $display("[TB] FAIL rmid_at_1110: got DAC_cs=%b dac_ch=%b expected 0/0", DAC_cs, dac_ch); end
    rst = 1'b0;
    step();
    checks++; if (flash_cs !== 1'b1 || DAC_cs !== 1'b1 || spi_mux !== 1'b1) begin errors++; $display("[TB] FAIL rmid_cs: got %b %b %b expected 1 1 1", flash_cs, DAC_cs, spi_mux); end
    checks++; if (DAC_load !== 1'b0 || sound_load !== 1'b0 || dac_ch !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pulses: got %b %b %b %b expected 0 0 0 0", DAC_load, sound_load, dac_ch, cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_cfg_ready: got %b expected 1", cfg_ready); end
    step();
    rst = 1'b1;
    step();
    checks++; if (sound_load !== 1'b1) begin errors++; $display("[TB] FAIL rmid_restart: got %b expected 1", sound_load); end
    measure_frame(0);
    checks++; if (m_len !== 1135 || m_load_a !== 1100) begin errors++; $display("[TB] FAIL rmid_defaults: got len %0d load %0d expected 1135 1100", m_len, m_load_a); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_cfg_midframe();
    test_cfg_invalid();
    test_cfg_at_wrap();
    test_enable_drop();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_timing_controller.md
SAMPLE_TIMING_CONTROLLER -- requirements
Module: sample_timing_controller

Interface
REQ-001 Parameter CNT_W, default 11: width of frame counter and config fields.
REQ-002 Parameter NUM_CH, default 2: number of DAC channels served per frame (1..8).
REQ-003 Parameter CH_W, default 1: width of dac_ch, SHALL equal max(1, clog2(NUM_CH)).
REQ-004 Parameter SLOT_LEN, default 16: cycles per DAC channel slot (>=2).
REQ-005 Parameter DEF_PERIOD, default 1134: reset value of period register (frame = period+1 cycles).
REQ-006 Parameter DEF_FLASH_LT, default 1100: reset value of flash window length.
REQ-007 One clock; reset is synchronous and active-low: clk input 1 (all logic on rising edge); rst input 1 (active-low, synchronous).
REQ-008 enable  input  1  run request; sampled every cycle.
REQ-009 cfg_valid  input  1; cfg_period  input  CNT_W; cfg_flash_lt  input  CNT_W  new timing, valid/ready handshake.
REQ-010 cfg_ready  output  1  high when no config is pending.
REQ-011 cfg_err  output  1  one-cycle pulse: accepted config rejected.
REQ-012 spi_mux  output  1  SPI mux select, equals flash_cs.
REQ-013 flash_cs  output  1  flash chip select, active-low.
REQ-014 DAC_cs  output  1  DAC chip select, active-low.
REQ-015 DAC_load  output  1  one-cycle pulse at start of each channel slot.
REQ-016 dac_ch  output  CH_W  channel index of current DAC slot.
REQ-017 sound_load  output  1  one-cycle pulse on first cycle of each frame.

Function
REQ-018 States IDLE, FLASH, DAC; counter count (CNT_W bits) and active regs period, flash_lt.
REQ-019 IDLE: count=0; enable=1 -> FLASH next cycle with count=0; else stay.
REQ-020 FLASH/DAC: count increments by 1 per cycle; state=FLASH while count<flash_lt, DAC while count>=flash_lt.
REQ-021 At count==period (frame wrap): enable=1 -> count=0, state FLASH; enable=0 -> IDLE; deasserting enable mid-frame never truncates the frame.
REQ-022 sound_load=1 iff state FLASH and count==0.
REQ-023 flash_cs=0 iff state FLASH; DAC_cs=0 iff state DAC; IDLE: both 1; spi_mux=flash_cs always.
REQ-024 Slot k (0..NUM_CH-1) spans count in [flash_lt+k*SLOT_LEN, flash_lt+(k+1)*SLOT_LEN-1]; DAC_load=1 on first cycle of each slot only.
REQ-025 dac_ch=k inside slot k; outside all slots (FLASH, IDLE, DAC tail) dac_ch=0.
REQ-026 Slot arithmetic SHALL use CNT_W+4 bits; no wrap-around aliasing.
REQ-027 Config accepted when cfg_valid & cfg_ready; valid iff cfg_flash_lt>=1 and cfg_flash_lt+NUM_CH*SLOT_LEN <= cfg_period+1.
REQ-028 Invalid config: discarded, cfg_err=1 cycle after acceptance, cfg_ready stays 1.
REQ-029 Valid config: stored as pending, cfg_ready=0 from next cycle until applied.
REQ-030 Pending applied at next frame wrap or while in IDLE (next cycle); cfg_ready returns 1 the cycle after apply.
REQ-031 Accept on the same cycle as a wrap: applied at the following wrap, not the current one.
REQ-032 Active period/flash_lt never change mid-frame.

Reset
REQ-033 rst=0 at any clock edge, including mid-frame: state IDLE, count=0, period=DEF_PERIOD, flash_lt=DEF_FLASH_LT, pending cleared.
REQ-034 Outputs during/after reset until enable: flash_cs=1, DAC_cs=1, spi_mux=1, DAC_load=0, sound_load=0, dac_ch=0, cfg_err=0, cfg_ready=1.

Verification
REQ-035 Defaults, enable=1 from reset: sound_load every 1135 cycles; flash_cs=0 for counts 0..1099; DAC_load at 1100 (dac_ch=0) and 1116 (dac_ch=1); DAC_cs=0 counts 1100..1134.
REQ-036 cfg 199/100 mid-frame: cfg_ready=0 next cycle; current frame stays 1135 cycles; next frame 200 cycles, DAC_load at 100, 116; cfg_ready=1 after wrap.
REQ-037 cfg 120/100 (100+32>121): cfg_err single pulse, timing unchanged, cfg_ready stays 1.
REQ-038 enable dropped at count 500: frame completes to 1134, then IDLE with flash_cs=DAC_cs=1; re-enable -> sound_load next cycle.
REQ-039 cfg accepted exactly at count==period: that wrap keeps old timing, new timing from following frame.
REQ-040 rst=0 at count 1110: next cycle IDLE, all outputs at REQ-034 values, defaults restored.
